// File: rtl/regbank_sb.sv
// regbank_sb: WIDTH x DEPTH register bank with 2 read ports, 1 write port, write-to-read bypass, busy scoreboard.
// Latency: read accepted at edge N -> o_data1/o_data2/o_rd_valid valid during cycle N+1; writes/locks land at the edge.
// Backpressure: o_rd_ready drops while a read address is busy (pending write); requester holds request until accepted.
//
// Ports:
//   i_clk, i_rst_n          clock; synchronous active-low reset
//   i_rd_req, o_rd_ready    read handshake (o_rd_ready is combinational)
//   i_addr1, i_addr2        read addresses
//   o_data1, o_data2        registered read data, o_rd_valid one-cycle pulse per accept
//   i_wr_en, i_addrdest,
//   i_datadest              write-back port; clears the busy bit of the written register
//   i_lock_en, i_lock_addr  marks a register busy (write pending)
//   o_busy                  registered scoreboard, one bit per register
module regbank_sb #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rd_req,
    output logic             o_rd_ready,
    input  logic [AW-1:0]    i_addr1,
    input  logic [AW-1:0]    i_addr2,
    output logic [WIDTH-1:0] o_data1,
    output logic [WIDTH-1:0] o_data2,
    output logic             o_rd_valid,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_addrdest,
    input  logic [WIDTH-1:0] i_datadest,
    input  logic             i_lock_en,
    input  logic [AW-1:0]    i_lock_addr,
    output logic [DEPTH-1:0] o_busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [WIDTH-1:0] r_data1;
    logic [WIDTH-1:0] r_data2;
    logic             r_rd_valid;

    // ------------------------------------------------------------------
    // Address qualification
    // A "live" address is in range and is not the hard-wired zero
    // register. Only live registers can be written, locked, read with a
    // non-zero value, or be busy.
    // ------------------------------------------------------------------
    logic w_a1_live;
    logic w_a2_live;
    logic w_dest_live;
    logic w_lock_live;

    always_comb begin
        w_a1_live   = (int'(i_addr1) < DEPTH);
        w_a2_live   = (int'(i_addr2) < DEPTH);
        w_dest_live = (int'(i_addrdest) < DEPTH);
        w_lock_live = (int'(i_lock_addr) < DEPTH);
        if (ZERO_REG != 0) begin
            if (i_addr1 == '0)     w_a1_live   = 1'b0;
            if (i_addr2 == '0)     w_a2_live   = 1'b0;
            if (i_addrdest == '0)  w_dest_live = 1'b0;
            if (i_lock_addr == '0) w_lock_live = 1'b0;
        end
    end

    logic w_wr_ok;
    logic w_lock_ok;

    assign w_wr_ok   = i_wr_en & w_dest_live;
    assign w_lock_ok = i_lock_en & w_lock_live;

    // ------------------------------------------------------------------
    // Read readiness
    // A busy register is still readable in the cycle it is being written,
    // because the bypass below forwards the incoming data.
    // ------------------------------------------------------------------
    logic w_hit1;
    logic w_hit2;
    logic w_busy1;
    logic w_busy2;
    logic w_ok1;
    logic w_ok2;
    logic w_accept;

    assign w_hit1 = w_wr_ok & (i_addrdest == i_addr1);
    assign w_hit2 = w_wr_ok & (i_addrdest == i_addr2);

    always_comb begin
        w_busy1 = 1'b0;
        w_busy2 = 1'b0;
        if (w_a1_live) w_busy1 = r_busy[i_addr1];
        if (w_a2_live) w_busy2 = r_busy[i_addr2];
    end

    assign w_ok1      = ~w_busy1 | w_hit1;
    assign w_ok2      = ~w_busy2 | w_hit2;
    assign o_rd_ready = w_ok1 & w_ok2;
    assign w_accept   = i_rd_req & o_rd_ready;

    // ------------------------------------------------------------------
    // Read data with write-first bypass
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_a1_live) w_rd1 = w_hit1 ? i_datadest : r_regs[i_addr1];
        if (w_a2_live) w_rd2 = w_hit2 ? i_datadest : r_regs[i_addr2];
    end

    // ------------------------------------------------------------------
    // Scoreboard next state: lock is applied after the write-clear so a
    // same-cycle write and lock of one register leaves it busy.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok)   w_busy_nxt[i_addrdest]  = 1'b0;
        if (w_lock_ok) w_busy_nxt[i_lock_addr] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy     <= '0;
            r_data1    <= '0;
            r_data2    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_regs[i_addrdest] <= i_datadest;
            end
            r_busy     <= w_busy_nxt;
            r_rd_valid <= w_accept;
            // Read data holds its last value when nothing is accepted.
            if (w_accept) begin
                r_data1 <= w_rd1;
                r_data2 <= w_rd2;
            end
        end
    end

    assign o_data1    = r_data1;
    assign o_data2    = r_data2;
    assign o_rd_valid = r_rd_valid;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_regbank_sb.sv
module tb_regbank_sb;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic        wr_en;
    logic        lock_en;
    logic [2:0]  addr1;
    logic [2:0]  addr2;
    logic [2:0]  addrdest;
    logic [2:0]  lock_addr;
    logic [15:0] datadest;

    // Instance A: 8x8, no zero register
    logic        a_ready;
    logic [7:0]  a_d1;
    logic [7:0]  a_d2;
    logic        a_vld;
    logic [7:0]  a_busy;

    // Instance B: 16-bit x 6 registers, zero register enabled
    logic        b_ready;
    logic [15:0] b_d1;
    logic [15:0] b_d2;
    logic        b_vld;
    logic [5:0]  b_busy;

    int n_chk;
    int n_fail;

    regbank_sb #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(rd_req), .o_rd_ready(a_ready),
        .i_addr1(addr1), .i_addr2(addr2), .o_data1(a_d1), .o_data2(a_d2),
        .o_rd_valid(a_vld), .i_wr_en(wr_en), .i_addrdest(addrdest),
        .i_datadest(datadest[7:0]), .i_lock_en(lock_en), .i_lock_addr(lock_addr),
        .o_busy(a_busy)
    );

    regbank_sb #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(rd_req), .o_rd_ready(b_ready),
        .i_addr1(addr1), .i_addr2(addr2), .o_data1(b_d1), .o_data2(b_d2),
        .o_rd_valid(b_vld), .i_wr_en(wr_en), .i_addrdest(addrdest),
        .i_datadest(datadest), .i_lock_en(lock_en), .i_lock_addr(lock_addr),
        .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: k=0 is instance A, k=1 is instance B.
    // ------------------------------------------------------------------
    logic [15:0] m_reg  [2][8];
    bit          m_busy [2][8];
    logic [15:0] m_d1   [2];
    logic [15:0] m_d2   [2];
    bit          m_vld  [2];

    function automatic int dep(int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic logic [15:0] msk(int k);
        return (k == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    // register exists and is not the constant-zero register
    function automatic bit live(int k, logic [2:0] a);
        return (int'(a) < dep(k)) && !(k == 1 && a == 3'd0);
    endfunction

    function automatic logic [15:0] rdval(int k, logic [2:0] a);
        if (!live(k, a)) return 16'h0000;
        if (wr_en && addrdest == a) return datadest & msk(k);
        return m_reg[k][a];
    endfunction

    function automatic bit addr_ok(int k, logic [2:0] a);
        if (!live(k, a)) return 1'b1;
        return !m_busy[k][a] || (wr_en && addrdest == a);
    endfunction

    function automatic bit m_ready(int k);
        return addr_ok(k, addr1) && addr_ok(k, addr2);
    endfunction

    function automatic void m_edge(int k);
        bit acc;
        if (!rst_n) begin
            for (int r = 0; r < 8; r++) begin
                m_reg[k][r]  = 16'h0000;
                m_busy[k][r] = 1'b0;
            end
            m_d1[k]  = 16'h0000;
            m_d2[k]  = 16'h0000;
            m_vld[k] = 1'b0;
            return;
        end
        acc = rd_req && m_ready(k);
        if (acc) begin
            m_d1[k] = rdval(k, addr1);
            m_d2[k] = rdval(k, addr2);
        end
        m_vld[k] = acc;
        if (wr_en && live(k, addrdest)) begin
            m_reg[k][addrdest]  = datadest & msk(k);
            m_busy[k][addrdest] = 1'b0;
        end
        if (lock_en && live(k, lock_addr)) m_busy[k][lock_addr] = 1'b1;
    endfunction

    function automatic logic [7:0] busy_vec(int k);
        logic [7:0] v;
        v = 8'h00;
        for (int r = 0; r < dep(k); r++) v[r] = m_busy[k][r];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        chk("A.data1",    {24'h0, a_d1},   {16'h0, m_d1[0]});
        chk("A.data2",    {24'h0, a_d2},   {16'h0, m_d2[0]});
        chk("A.rd_valid", {31'h0, a_vld},  {31'h0, m_vld[0]});
        chk("A.busy",     {24'h0, a_busy}, {24'h0, busy_vec(0)});
        chk("B.data1",    {16'h0, b_d1},   {16'h0, m_d1[1]});
        chk("B.data2",    {16'h0, b_d2},   {16'h0, m_d2[1]});
        chk("B.rd_valid", {31'h0, b_vld},  {31'h0, m_vld[1]});
        chk("B.busy",     {26'h0, b_busy}, {24'h0, busy_vec(1)});
    endtask

    // Called shortly after a falling edge with inputs already applied.
    task automatic cycle();
        #1;
        chk("A.rd_ready", {31'h0, a_ready}, {31'h0, m_ready(0)});
        chk("B.rd_ready", {31'h0, b_ready}, {31'h0, m_ready(1)});
        @(posedge clk);
        m_edge(0);
        m_edge(1);
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle();
        rd_req  = 1'b0;
        wr_en   = 1'b0;
        lock_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        idle();
        wr_en    = 1'b1;
        addrdest = a;
        datadest = d;
        cycle();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n = 1'b0; rd_req = 1'b0; wr_en = 1'b0; lock_en = 1'b0;
        addr1 = 3'd0; addr2 = 3'd0; addrdest = 3'd0; lock_addr = 3'd0; datadest = 16'h0;

        // Initial reset
        repeat (2) @(posedge clk);
        m_edge(0);
        m_edge(1);
        @(negedge clk);
        check_outs();
        chk("A.busy_after_reset", {24'h0, a_busy}, 32'h0);
        chk("A.valid_after_reset", {31'h0, a_vld}, 32'h0);
        rst_n = 1'b1;

        // Any address pair is ready straight after reset
        for (int i = 0; i < 4; i++) begin
            addr1 = 3'(i);
            addr2 = 3'(7 - i);
            #1;
            chk("A.ready_after_reset", {31'h0, a_ready}, 32'h1);
            chk("B.ready_after_reset", {31'h0, b_ready}, 32'h1);
        end

        // Write then read
        wr(3'd3, 16'h00A5);
        idle(); rd_req = 1'b1; addr1 = 3'd3; addr2 = 3'd0;
        cycle();
        chk("A.read_reg3", {24'h0, a_d1}, 32'hA5);
        chk("A.read_reg0", {24'h0, a_d2}, 32'h0);
        chk("A.read_valid", {31'h0, a_vld}, 32'h1);

        // Reset clears registers and read data
        idle(); rst_n = 1'b0;
        cycle();
        chk("A.data_rst", {24'h0, a_d1}, 32'h0);
        rst_n = 1'b1;
        idle(); rd_req = 1'b1; addr1 = 3'd3; addr2 = 3'd3;
        cycle();
        chk("A.reg3_cleared", {24'h0, a_d1}, 32'h0);

        // Bypass: write-first into a same-cycle read
        wr(3'd5, 16'h0011);
        idle(); wr_en = 1'b1; addrdest = 3'd5; datadest = 16'h007E;
        rd_req = 1'b1; addr1 = 3'd5; addr2 = 3'd1;
        cycle();
        chk("A.bypass", {24'h0, a_d1}, 32'h7E);

        // Scoreboard stall until write-back
        idle(); lock_en = 1'b1; lock_addr = 3'd2;
        cycle();
        idle(); rd_req = 1'b1; addr1 = 3'd2; addr2 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("A.stall_ready", {31'h0, a_ready}, 32'h0);
            chk("A.stall_valid", {31'h0, a_vld}, 32'h0);
        end
        wr_en = 1'b1; addrdest = 3'd2; datadest = 16'h003C;
        #1;
        chk("A.ready_on_write", {31'h0, a_ready}, 32'h1);
        cycle();
        chk("A.unstall_data", {24'h0, a_d1}, 32'h3C);
        chk("A.unstall_busy2", {31'h0, a_busy[2]}, 32'h0);

        // Same-cycle lock and write: lock wins
        idle(); wr_en = 1'b1; lock_en = 1'b1; addrdest = 3'd4; lock_addr = 3'd4; datadest = 16'h005A;
        cycle();
        chk("A.lock_wins", {31'h0, a_busy[4]}, 32'h1);
        idle(); rd_req = 1'b1; addr1 = 3'd4; addr2 = 3'd4;
        cycle();
        chk("A.reg4_stall", {31'h0, a_vld}, 32'h0);
        wr_en = 1'b1; addrdest = 3'd4; datadest = 16'h0066;
        cycle();
        chk("A.reg4_release", {24'h0, a_d1}, 32'h66);

        // Lock in the accept cycle does not block that accept
        idle(); rd_req = 1'b1; addr1 = 3'd6; addr2 = 3'd6; lock_en = 1'b1; lock_addr = 3'd6;
        cycle();
        chk("A.lock_same_accept", {31'h0, a_vld}, 32'h1);
        chk("A.lock_same_busy6", {31'h0, a_busy[6]}, 32'h1);
        wr(3'd6, 16'h0021);

        // Zero register on instance B
        wr(3'd0, 16'hFFFF);
        idle(); lock_en = 1'b1; lock_addr = 3'd0;
        cycle();
        idle(); rd_req = 1'b1; addr1 = 3'd0; addr2 = 3'd0;
        #1;
        chk("B.zero_ready", {31'h0, b_ready}, 32'h1);
        cycle();
        chk("B.zero_data", {16'h0, b_d1}, 32'h0);
        chk("B.zero_valid", {31'h0, b_vld}, 32'h1);
        chk("B.zero_busy", {31'h0, b_busy[0]}, 32'h0);

        // Out-of-range address on instance B
        wr(3'd7, 16'h1234);
        idle(); rd_req = 1'b1; addr1 = 3'd7; addr2 = 3'd6;
        cycle();
        chk("B.oor_data1", {16'h0, b_d1}, 32'h0);
        chk("B.oor_data2", {16'h0, b_d2}, 32'h0);
        chk("B.oor_valid", {31'h0, b_vld}, 32'h1);

        // Back-to-back reads of all six B registers
        for (int i = 0; i < 6; i++) wr(3'(i), 16'h1000 + 16'(i * 16'h0111));
        for (int i = 0; i < 6; i++) begin
            idle(); rd_req = 1'b1; addr1 = 3'(i); addr2 = 3'(5 - i);
            cycle();
            chk("B.b2b_valid", {31'h0, b_vld}, 32'h1);
            chk("B.b2b_data1", {16'h0, b_d1},
                (i == 0) ? 32'h0 : 32'(16'h1000 + 16'(i * 16'h0111)));
        end

        // Reset during an accept cycle
        idle(); rd_req = 1'b1; addr1 = 3'd1; addr2 = 3'd2; rst_n = 1'b0;
        cycle();
        chk("A.rst_accept_valid", {31'h0, a_vld}, 32'h0);
        chk("B.rst_accept_valid", {31'h0, b_vld}, 32'h0);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst_n     = ($urandom_range(0, 79) != 0);
            rd_req    = ($urandom_range(0, 2) != 0);
            wr_en     = ($urandom_range(0, 1) != 0);
            lock_en   = ($urandom_range(0, 2) == 0);
            addr1     = 3'($urandom_range(0, 7));
            addr2     = 3'($urandom_range(0, 7));
            addrdest  = 3'($urandom_range(0, 7));
            lock_addr = 3'($urandom_range(0, 7));
            datadest  = 16'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
